// File: rtl/imem_pkg.sv
// Shared types for the shrv32 instruction memory and its byte-serial loader.
package imem_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      WRITE
   } ld_state_t;

   localparam word_t FILL_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/imem_loader.sv
// Byte-serial image loader: assembles little-endian words and streams them to memory.
module imem_loader
   import imem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int IW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ld_start,
   input  logic          ld_valid,
   input  logic [7:0]    ld_data,
   input  logic          ld_last,
   output logic          ld_ready,
   output logic          ld_busy,
   output logic          ld_ovf,
   output logic          wr_en,
   output logic [IW-1:0] wr_idx,
   output word_t         wr_data
);

   ld_state_t   state;
   ld_state_t   state_nx;
   logic [IW:0] wptr;
   logic [1:0]  bcnt;
   logic        last_q;
   logic        take;
   word_t       asm_q;

   // A restart on the same edge as a byte wins; the byte is not taken
   assign take    = ld_ready & ld_valid & ~ld_start;
   assign wr_idx  = wptr[IW-1:0];
   assign wr_data = asm_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (ld_start) state_nx = COLLECT;
         COLLECT: if (take && (bcnt == 2'd3 || ld_last)) state_nx = WRITE;
         WRITE:   state_nx = (last_q && !ld_start) ? IDLE : COLLECT;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      ld_ready = (state == COLLECT);
      ld_busy  = (state != IDLE);
      wr_en    = (state == WRITE) && !wptr[IW];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr   <= '0;
         bcnt   <= '0;
         last_q <= 1'b0;
         asm_q  <= '0;
         ld_ovf <= 1'b0;
      end else if (ld_start) begin
         wptr   <= '0;
         bcnt   <= '0;
         last_q <= 1'b0;
         ld_ovf <= 1'b0;
      end else begin
         if (take) begin
            if (bcnt == 2'd0) begin
               asm_q <= {24'h0, ld_data};
            end else begin
               asm_q[{bcnt, 3'b000} +: 8] <= ld_data;
            end
            bcnt   <= bcnt + 2'd1;
            last_q <= ld_last;
         end
         if (state == WRITE) begin
            bcnt <= '0;
            // wptr MSB set means the image ran past the end
            if (wptr[IW]) begin
               ld_ovf <= 1'b1;
            end else begin
               wptr <= wptr + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/imem_rom.sv
// shrv32 instruction memory: 1-cycle fetch with stall hold and fault flagging.
// Define IMEM_LOADER_EN to add the run-time byte-serial loader.
module imem_rom
   import imem_pkg::*;
#(
   parameter int    DEPTH_WORDS = 256,
   parameter word_t BASE_ADDR   = 32'h0,
   parameter word_t FILL_WORD   = FILL_DEFAULT,
   parameter string INIT_FILE   = "prog.hex"
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ,
   input  logic [31:0] A,
   input  logic        STALL,
   output logic [31:0] RD,
   output logic        RVALID,
   output logic        FAULT,
   input  logic        LD_START,
   input  logic        LD_VALID,
   input  logic [7:0]  LD_DATA,
   input  logic        LD_LAST,
   output logic        LD_READY,
   output logic        LD_BUSY,
   output logic        LD_OVF
);

   localparam int IW = $clog2(DEPTH_WORDS);

   word_t         mem [DEPTH_WORDS];
   word_t         off;
   logic [IW-1:0] idx;
   logic          in_range;
   logic          bad;
   logic          busy;
   logic          accept;
   logic          unused_off;

   initial begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = '0;
   end

   assign off        = A - BASE_ADDR;
   assign idx        = off[IW+1:2];
   assign in_range   = ({2'b00, off[31:2]} < 32'(DEPTH_WORDS));
   assign bad        = (A[1:0] != 2'b00) || !in_range;
   assign accept     = REQ && !STALL && !busy;
   assign unused_off = &{1'b0, off[1:0]};

   always_ff @(posedge CLK) begin
      if (RST) begin
         RD     <= '0;
         RVALID <= 1'b0;
         FAULT  <= 1'b0;
      end else if (!STALL) begin
         RVALID <= accept;
         if (accept) begin
            FAULT <= bad;
            RD    <= bad ? FILL_WORD : mem[idx];
         end
      end
   end

`ifdef IMEM_LOADER_EN
   logic          wr_en;
   logic [IW-1:0] wr_idx;
   word_t         wr_data;

   imem_loader #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_loader (
      .clk      (CLK),
      .rst      (RST),
      .ld_start (LD_START),
      .ld_valid (LD_VALID),
      .ld_data  (LD_DATA),
      .ld_last  (LD_LAST),
      .ld_ready (LD_READY),
      .ld_busy  (LD_BUSY),
      .ld_ovf   (LD_OVF),
      .wr_en    (wr_en),
      .wr_idx   (wr_idx),
      .wr_data  (wr_data)
   );

   assign busy = LD_BUSY;

   always_ff @(posedge CLK) begin
      if (wr_en) mem[wr_idx] <= wr_data;
   end
`else
   logic unused_ld;

   assign LD_READY  = 1'b0;
   assign LD_BUSY   = 1'b0;
   assign LD_OVF    = 1'b0;
   assign busy      = 1'b0;
   assign unused_ld = &{1'b0, LD_START, LD_VALID, LD_DATA, LD_LAST};
`endif

endmodule

// File: tb/tb_imem_rom.sv
// Scoreboard bench for imem_rom: fetch, faults, stall hold and (with IMEM_LOADER_EN) the loader.
module tb_imem_rom;

   localparam int          DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h100;
   localparam logic [31:0] FILL  = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic [31:0] a = '0;
   logic        stall = 1'b0;
   logic [31:0] rd;
   logic        rvalid;
   logic        fault;
   logic        ld_start = 1'b0;
   logic        ld_valid = 1'b0;
   logic [7:0]  ld_data = '0;
   logic        ld_last = 1'b0;
   logic        ld_ready;
   logic        ld_busy;
   logic        ld_ovf;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model [DEPTH];
   logic [32:0] exp_q [$];

   always #5 clk = ~clk;

   imem_rom #(
      .DEPTH_WORDS (DEPTH),
      .BASE_ADDR   (BASE),
      .FILL_WORD   (FILL),
      .INIT_FILE   ("")
   ) dut (
      .CLK      (clk),
      .RST      (rst),
      .REQ      (req),
      .A        (a),
      .STALL    (stall),
      .RD       (rd),
      .RVALID   (rvalid),
      .FAULT    (fault),
      .LD_START (ld_start),
      .LD_VALID (ld_valid),
      .LD_DATA  (ld_data),
      .LD_LAST  (ld_last),
      .LD_READY (ld_ready),
      .LD_BUSY  (ld_busy),
      .LD_OVF   (ld_ovf)
   );

   function automatic logic [31:0] pat(input int i);
      return 32'h13579BDF ^ (32'(i) * 32'h01010101);
   endfunction

   function automatic logic [32:0] expect_fetch(input logic [31:0] addr);
      logic [31:0] o;
      o = addr - BASE;
      if (addr[1:0] != 2'b00 || o[31:2] >= 30'(DEPTH)) return {1'b1, FILL};
      return {1'b0, model[o[5:2]]};
   endfunction

   // One request, response sampled at the following negedge
   task automatic issue(input logic [31:0] addr);
      req = 1'b1;
      a   = addr;
      exp_q.push_back(expect_fetch(addr));
      @(negedge clk);
      req = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({rd, rvalid, fault} !== 34'h0) begin
         errors++;
         $display("FAIL reset_fetch: got rd=%h rvalid=%b fault=%b expected all 0", rd, rvalid, fault);
      end
      checks++;
      if ({ld_ready, ld_busy, ld_ovf} !== 3'b000) begin
         errors++;
         $display("FAIL reset_loader: got ready/busy/ovf=%b%b%b expected 000", ld_ready, ld_busy, ld_ovf);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_fetch();
      logic [31:0] addrs [10];
      logic [32:0] e;
      addrs = '{BASE, BASE + 32'h4, BASE + 32'h3C, BASE + 32'h2, BASE + 32'd64,
                BASE - 32'h4, 32'h0, 32'hFFFF_FFFC, BASE + 32'h21, BASE + 32'h18};
      foreach (addrs[i]) begin
         issue(addrs[i]);
         checks++;
         if (rvalid !== 1'b1 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL fetch_%h: rvalid=%b expected 1", addrs[i], rvalid);
            exp_q.delete();
         end else begin
            e = exp_q.pop_front();
            if ({fault, rd} !== e) begin
               errors++;
               $display("FAIL fetch_%h: got fault=%b rd=%h expected fault=%b rd=%h",
                        addrs[i], fault, rd, e[32], e[31:0]);
            end
         end
      end
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b0) begin
         errors++;
         $display("FAIL idle_rvalid: got %b expected 0", rvalid);
      end
   endtask

   task automatic test_stall();
      logic [32:0] e;
      issue(BASE + 32'h4);
      e = exp_q.size() != 0 ? exp_q.pop_front() : 33'h0;
      checks++;
      if ({rvalid, fault, rd} !== {1'b1, e}) begin
         errors++;
         $display("FAIL stall_first: got %b/%b/%h expected 1/%b/%h", rvalid, fault, rd, e[32], e[31:0]);
      end
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         req = 1'b1;
         a   = (k == 1) ? BASE + 32'h2 : BASE + 32'h8 + 32'(4 * k);
         @(negedge clk);
         checks++;
         if ({rvalid, fault, rd} !== {1'b1, e}) begin
            errors++;
            $display("FAIL stall_hold_%0d: got %b/%b/%h expected 1/%b/%h",
                     k, rvalid, fault, rd, e[32], e[31:0]);
         end
      end
      stall = 1'b0;
      issue(BASE + 32'h20);
      e = exp_q.size() != 0 ? exp_q.pop_front() : 33'h0;
      checks++;
      if ({rvalid, fault, rd} !== {1'b1, e}) begin
         errors++;
         $display("FAIL stall_release: got %b/%b/%h expected 1/%b/%h", rvalid, fault, rd, e[32], e[31:0]);
      end
   endtask

`ifdef IMEM_LOADER_EN
   task automatic send_byte(input logic [7:0] b, input logic last);
      int n = 0;
      while (ld_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (ld_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL ld_ready_timeout: got %b expected 1", ld_ready);
      end
      ld_valid = 1'b1;
      ld_data  = b;
      ld_last  = last;
      @(negedge clk);
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input logic last);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], last && k == 3);
   endtask

   task automatic start_load();
      ld_start = 1'b1;
      @(negedge clk);
      ld_start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (ld_busy !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (ld_busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle: got busy=%b expected 0", name, ld_busy);
      end
   endtask

   task automatic test_readback(input string name);
      logic [32:0] e;
      for (int i = 0; i < DEPTH; i++) begin
         issue(BASE + 32'(4 * i));
         checks++;
         if (rvalid !== 1'b1 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_word%0d: rvalid=%b expected 1", name, i, rvalid);
            exp_q.delete();
         end else begin
            e = exp_q.pop_front();
            if ({fault, rd} !== e) begin
               errors++;
               $display("FAIL %s_word%0d: got %b/%h expected %b/%h", name, i, fault, rd, e[32], e[31:0]);
            end
         end
      end
   endtask

   task automatic test_overflow();
      start_load();
      for (int i = 0; i <= DEPTH; i++) send_word(pat(i), i == DEPTH);
      wait_idle("ovf");
      checks++;
      if (ld_ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_flag: got %b expected 1", ld_ovf);
      end
      for (int i = 0; i < DEPTH; i++) model[i] = pat(i);
      test_readback("ovf");
   endtask

   task automatic test_restart();
      start_load();
      for (int i = 0; i <= DEPTH; i++) send_word(~pat(i), 1'b0);
      @(negedge clk);
      checks++;
      if ({ld_ovf, ld_busy, ld_ready} !== 3'b111) begin
         errors++;
         $display("FAIL restart_pre: got ovf/busy/ready=%b%b%b expected 111", ld_ovf, ld_busy, ld_ready);
      end
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      ld_start = 1'b1;
      ld_valid = 1'b1;
      ld_data  = 8'hAA;
      @(negedge clk);
      ld_start = 1'b0;
      ld_valid = 1'b0;
      checks++;
      if ({ld_ovf, ld_busy} !== 2'b01) begin
         errors++;
         $display("FAIL restart_clear: got ovf/busy=%b%b expected 01", ld_ovf, ld_busy);
      end
      send_word(32'h00100F93, 1'b0);
      send_byte(8'h8B, 1'b0);
      send_byte(8'h40, 1'b1);
      wait_idle("restart");
      for (int i = 0; i < DEPTH; i++) model[i] = ~pat(i);
      model[0] = 32'h00100F93;
      model[1] = 32'h0000408B;
      test_readback("restart");
   endtask

   task automatic test_load_inflight();
      logic [32:0] e;
      req      = 1'b1;
      a        = BASE + 32'h8;
      ld_start = 1'b1;
      exp_q.push_back(expect_fetch(a));
      @(negedge clk);
      ld_start = 1'b0;
      e = exp_q.size() != 0 ? exp_q.pop_front() : 33'h0;
      checks++;
      if ({rvalid, fault, rd, ld_busy} !== {1'b1, e, 1'b1}) begin
         errors++;
         $display("FAIL inflight: got %b/%b/%h busy=%b expected 1/%b/%h busy=1",
                  rvalid, fault, rd, ld_busy, e[32], e[31:0]);
      end
      @(negedge clk);
      req = 1'b0;
      checks++;
      if (rvalid !== 1'b0) begin
         errors++;
         $display("FAIL req_during_load: got rvalid=%b expected 0", rvalid);
      end
      send_word(32'hA1A2A3A4, 1'b0);
      send_word(32'hB1B2B3B4, 1'b0);
      checks++;
      if ({ld_ready, ld_busy} !== 2'b01) begin
         errors++;
         $display("FAIL write_state: got ready/busy=%b%b expected 01", ld_ready, ld_busy);
      end
      start_load();
      send_word(32'hC1C2C3C4, 1'b1);
      wait_idle("inwrite");
      model[0] = 32'hC1C2C3C4;
      model[1] = 32'hB1B2B3B4;
      test_readback("inwrite");
   endtask

   task automatic test_reset_midload();
      start_load();
      for (int i = 0; i < 3; i++) send_word(32'h5000_0000 + 32'(i), 1'b0);
      send_byte(8'h77, 1'b0);
      send_byte(8'h66, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({ld_busy, ld_ready, ld_ovf, rvalid} !== 4'b0000) begin
         errors++;
         $display("FAIL midload_reset: got busy/ready/ovf/rvalid=%b%b%b%b expected 0000",
                  ld_busy, ld_ready, ld_ovf, rvalid);
      end
      for (int i = 0; i < 3; i++) model[i] = 32'h5000_0000 + 32'(i);
      test_readback("midload");
   endtask
`else
   task automatic test_ties();
      ld_start = 1'b1;
      ld_valid = 1'b1;
      ld_last  = 1'b1;
      ld_data  = 8'h5A;
      repeat (2) @(negedge clk);
      checks++;
      if ({ld_ready, ld_busy, ld_ovf} !== 3'b000) begin
         errors++;
         $display("FAIL ld_ties: got ready/busy/ovf=%b%b%b expected 000", ld_ready, ld_busy, ld_ovf);
      end
      ld_start = 1'b0;
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask
`endif

   initial begin
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
`ifndef IMEM_LOADER_EN
      #1;
      for (int i = 0; i < DEPTH; i++) begin
         model[i]   = pat(i);
         dut.mem[i] = pat(i);
      end
`endif
      test_reset();
`ifdef IMEM_LOADER_EN
      test_overflow();
      test_fetch();
      test_stall();
      test_restart();
      test_load_inflight();
      test_reset_midload();
`else
      test_fetch();
      test_stall();
      test_ties();
      test_fetch();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
